// File: rtl/wavetable_nco_mc.sv
// wavetable_nco_mc
//   Multi-channel wavetable NCO. NUM_CH fixed-point phase accumulators
//   (ADDR_W integer . FRAC_W fraction bits) share one DEPTH-entry sample RAM.
//   Every STROBE_DIV clocks, all phases advance by their step. The channels
//   are then read from the RAM one per cycle, and all outputs are presented
//   together with a one-cycle valid_o pulse. The table is loaded through an
//   independent write port, so it can be updated while the block runs.
// Ports
//   clk, rst_n  clock; asynchronous active-low reset
//   run_i       1 = sample-tick counter runs, 0 = counter/phases/outputs frozen
//   sync_i      1-cycle pulse: zero all phases and restart the tick counter
//   step_i      per-channel phase step, channel k at [k*SW +: SW]
//   wr_en_i     table write enable (addresses >= DEPTH are ignored)
//   wr_addr_i   table write address
//   wr_data_i   table write data
//   data_o      per-channel sample, channel k at [k*DATA_W +: DATA_W]
//   valid_o     1-cycle pulse in the cycle data_o takes new values
module wavetable_nco_mc #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH      = 6000,
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned FRAC_W     = 8,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned STROBE_DIV = 521
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                run_i,
    input  logic                                sync_i,
    input  logic [NUM_CH*(ADDR_W+FRAC_W)-1:0]   step_i,
    input  logic                                wr_en_i,
    input  logic [ADDR_W-1:0]                   wr_addr_i,
    input  logic [DATA_W-1:0]                   wr_data_i,
    output logic [NUM_CH*DATA_W-1:0]            data_o,
    output logic                                valid_o
);
    localparam int unsigned SW    = ADDR_W + FRAC_W;
    localparam int unsigned CNT_W = (STROBE_DIV > 1) ? $clog2(STROBE_DIV) : 1;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] MAX_INT  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STROBE_DIV - 1);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, RD, LAST, COMMIT} state_t;

    state_t                          state_q, state_d;
    logic [CH_W-1:0]                 ch_q, ch_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            tick;
    logic [NUM_CH-1:0][SW-1:0]       phase_q, phase_d;
    logic [NUM_CH-1:0][ADDR_W-1:0]   cap_q, cap_d;
    logic [NUM_CH-1:0][DATA_W-1:0]   shadow_q;
    logic [NUM_CH-1:0][DATA_W-1:0]   commit_d;
    logic [NUM_CH*DATA_W-1:0]        data_q;
    logic [DATA_W-1:0]               mem [DEPTH];
    logic [DATA_W-1:0]               rd_data_q;
    logic [ADDR_W-1:0]               rd_addr;

    // One phase advance: saturate the step's integer part, add, and wrap
    // the integer part modulo DEPTH (the sum is always below 2*DEPTH).
    function automatic logic [SW-1:0] advance(input logic [SW-1:0] ph,
                                              input logic [SW-1:0] st);
        logic [ADDR_W-1:0] st_int;
        logic [SW:0]       sum;
        logic [ADDR_W:0]   sum_int;
        st_int  = (st[SW-1:FRAC_W] >= DEPTH_A) ? MAX_INT : st[SW-1:FRAC_W];
        sum     = {1'b0, ph} + {1'b0, st_int, st[FRAC_W-1:0]};
        sum_int = sum[SW:FRAC_W];
        if (sum_int >= DEPTH_W) begin
            sum_int = sum_int - DEPTH_W;
        end
        return {sum_int[ADDR_W-1:0], sum[FRAC_W-1:0]};
    endfunction

    assign tick = run_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (sync_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // The read sequence works from addresses captured at the tick, so a sync
    // arriving mid-sequence does not disturb the reads already in flight.
    always_comb begin
        phase_d = phase_q;
        cap_d   = cap_q;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (sync_i) begin
                phase_d[k] = '0;
            end else if (tick) begin
                phase_d[k] = advance(phase_q[k], step_i[k*SW +: SW]);
            end
            if (tick && (state_q == IDLE)) begin
                cap_d[k] = phase_d[k][SW-1:FRAC_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = RD;
                    ch_d    = '0;
                end
            end
            RD: begin
                if (ch_q == CH_LAST) begin
                    state_d = LAST;
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            LAST:    state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The last channel's read data is merged straight into the output word
    // while in LAST, so data_o and valid_o both change on entry to COMMIT.
    always_comb begin
        commit_d          = shadow_q;
        commit_d[CH_LAST] = rd_data_q;
    end

    assign rd_addr = cap_q[ch_q];

    always_ff @(posedge clk) begin
        if (wr_en_i && (wr_addr_i < DEPTH_A)) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            cnt_q    <= '0;
            phase_q  <= '0;
            cap_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            cap_q   <= cap_d;
            // Data for the channel read in the previous RD cycle.
            if ((state_q == RD) && (ch_q != '0)) begin
                shadow_q[ch_q - CH_W'(1)] <= rd_data_q;
            end
            if (state_q == LAST) begin
                data_q <= commit_d;
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = (state_q == COMMIT);

endmodule

// File: tb/tb_wavetable_nco_mc.sv
// tb_wavetable_nco_mc
//   Scoreboard bench for wavetable_nco_mc. The stimulus process queues the
//   expected (cycle, data_o) of every output pulse; a monitor on the falling
//   edge pops and compares whenever valid_o is high, and tracks any change
//   of data_o outside a valid cycle.
module tb_wavetable_nco_mc;
    localparam int SW  = 21;
    localparam int NCH = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                run_i;
    logic                sync_i;
    logic [NCH*SW-1:0]   step_i;
    logic                wr_en_i;
    logic [12:0]         wr_addr_i;
    logic [7:0]          wr_data_i;
    logic [15:0]         data_o;
    logic                valid_o;

    typedef struct {
        int          at;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          stray = 0;
    logic [15:0] prev_data = '0;

    wavetable_nco_mc #(
        .DATA_W(8), .DEPTH(6000), .ADDR_W(13), .FRAC_W(8),
        .NUM_CH(2), .STROBE_DIV(521)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run_i(run_i), .sync_i(sync_i),
        .step_i(step_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i), .data_o(data_o), .valid_o(valid_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void push(input int at, input int ch0, input int ch1);
        exp_t e;
        e.at   = at;
        e.data = {ch1[7:0], ch0[7:0]};
        sb.push_back(e);
    endfunction

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_steps(input int s0, input int s1);
        step_i[0  +: SW] = s0[SW-1:0];
        step_i[SW +: SW] = s1[SW-1:0];
    endtask

    task automatic write1(input int addr, input int data);
        wr_en_i   = 1'b1;
        wr_addr_i = 13'(addr);
        wr_data_i = 8'(data);
        @(posedge clk);
        #1;
        wr_en_i   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_data = data_o;
        end else begin
            if ((data_o !== prev_data) && !valid_o) stray++;
            prev_data = data_o;
            if (valid_o) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_valid: got data 0x%0h at cycle %0d, expected no pulse", data_o, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("valid_cycle", cyc, e.at);
                    chk("data_o", {16'h0, data_o}, {16'h0, e.data});
                end
            end
        end
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation exceeded 60000 cycles, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, t, t4, p, tick5, s2, w1, w2, w3, w4, u1, u2, u3, u4;
        rst_n = 1'b0; run_i = 1'b0; sync_i = 1'b0; step_i = '0;
        wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
        goto(3);
        chk("reset_valid", {31'h0, valid_o}, 0);
        chk("reset_data", {16'h0, data_o}, 0);
        rst_n = 1'b1;

        // Table load: RAM[a] = a mod 256; out-of-range writes must be ignored.
        for (int a = 0; a < 6000; a++) begin
            wr_en_i   = 1'b1;
            wr_addr_i = 13'(a);
            wr_data_i = 8'(a);
            @(posedge clk);
            #1;
        end
        wr_en_i = 1'b0;
        write1(6000, 8'hAA);
        write1(8191, 8'h55);

        // Steps 1.0 / 2.5, aligned by a sync pulse.
        set_steps(256, 640);
        run_i = 1'b1; sync_i = 1'b1; s = cyc;
        @(posedge clk); #1; sync_i = 1'b0;
        t  = s + 521;
        push(t + 4, 1, 2);
        push(t + 521 + 4, 2, 5);
        push(t + 1042 + 4, 3, 7);
        push(t + 1563 + 4, 4, 10);
        t4 = t + 1563;

        // Freeze for 1000 cycles with the counter at 99.
        p = t4 + 100;
        tick5 = p + 1000 + 421;
        push(tick5 + 4, 5, 12);
        goto(p);        run_i = 1'b0;
        goto(p + 1000); run_i = 1'b1;

        // Wrap and step saturation.
        goto(tick5 + 10);
        set_steps(5998 * 256, 0);
        sync_i = 1'b1; s2 = cyc;
        @(posedge clk); #1; sync_i = 1'b0;
        w1 = s2 + 521;
        push(w1 + 4, 8'h6E, 0);
        goto(w1 + 10);
        set_steps(7 * 256 + 128, 0);
        w2 = w1 + 521;
        push(w2 + 4, 5, 0);
        goto(w2 + 10);
        set_steps(6500 * 256, 6500 * 256);
        w3 = w2 + 521;
        push(w3 + 4, 4, 8'h6F);

        // Sync in the tick cycle: phases zeroed, read sequence still runs.
        goto(w3 + 10);
        set_steps(256, 640);
        w4 = w3 + 521;
        push(w4 + 4, 0, 0);
        push(w4 + 521 + 4, 1, 2);
        goto(w4); sync_i = 1'b1;
        goto(w4 + 1); sync_i = 1'b0;

        // Writes while running; same-cycle read returns old data.
        u1 = w4 + 521;
        u2 = u1 + 521;
        u3 = u2 + 521;
        u4 = u3 + 521;
        push(u2 + 4, 8'hC3, 8'h5A);
        push(u3 + 4, 3, 7);
        goto(u1 + 50);
        write1(2, 8'hC3);
        write1(5, 8'h5A);
        goto(u3 + 1);
        write1(3, 8'h77);

        // Reset one cycle after a tick: sequence abandoned, outputs cleared.
        goto(u4 + 1);
        rst_n = 1'b0; run_i = 1'b0;
        goto(u4 + 3);
        chk("midseq_rst_valid", {31'h0, valid_o}, 0);
        chk("midseq_rst_data", {16'h0, data_o}, 0);
        rst_n = 1'b1;
        goto(u4 + 700);

        chk("scoreboard_drained", sb.size(), 0);
        chk("stray_data_changes", stray, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
